// File: rtl/ysyx_220066_mdu.sv
// ysyx_220066_mdu: iterative RISC-V M-extension multiply/divide unit.
// One bit per cycle: radix-2 shift-add multiply and restoring divide, both
// on operand magnitudes, with the result sign applied in the final step.
// Divide-by-zero and signed overflow are resolved at accept time.
module ysyx_220066_mdu #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic            word,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);
    // Word-variant width; clamps so narrow builds still elaborate.
    localparam int WW = (XLEN < 32) ? XLEN : 32;
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W = {{(XLEN-WW+1){1'b1}}, {(WW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    // Extend the low WW bits to XLEN, signed or unsigned.
    function automatic logic [XLEN-1:0] ext_w(input logic [XLEN-1:0] x, input logic sgn);
        logic [XLEN-1:0] r;
        for (int i = 0; i < XLEN; i++)
            r[i] = (i < WW) ? x[i] : (sgn & x[WW-1]);
        return r;
    endfunction

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              word_q, word_d, neg_q, neg_d, rneg_q, rneg_d;
    // opa: multiplicand (shifts left) / divisor in the low half.
    // opb: multiplier (shifts right) / dividend shifting into quotient.
    // acc: product / partial remainder in the low half.
    logic [2*XLEN-1:0] opa_q, opa_d, acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d, res_q, res_d;
    logic              in_ready_q, in_ready_d, out_valid_q, out_valid_d;

    logic              a_sgn, b_sgn, a_neg, b_neg, div0, ovf;
    logic [XLEN-1:0]   a_ext, b_ext, mag_a, mag_b, spec_raw, special;
    logic [XLEN:0]     div_sh, div_df;
    logic [2*XLEN-1:0] opa_n, acc_n, prod;
    logic [XLEN-1:0]   opb_n, quo, rem, fin_raw, fin;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = res_q;

    // Decode the request currently on the inputs: extension, magnitudes, special cases.
    always_comb begin
        a_sgn    = op[2] ? ~op[0] : (op[1:0] != 2'd3);
        b_sgn    = op[2] ? ~op[0] : ~op[1];
        a_ext    = word ? ext_w(src1, a_sgn) : src1;
        b_ext    = word ? ext_w(src2, b_sgn) : src2;
        a_neg    = a_sgn & a_ext[XLEN-1];
        b_neg    = b_sgn & b_ext[XLEN-1];
        mag_a    = a_neg ? -a_ext : a_ext;
        mag_b    = b_neg ? -b_ext : b_ext;
        div0     = op[2] & (b_ext == '0);
        ovf      = op[2] & ~op[0] & (a_ext == (word ? MIN_W : MIN_X)) & (&b_ext);
        if (div0)
            spec_raw = op[1] ? a_ext : '1;
        else
            spec_raw = op[1] ? '0 : a_ext;
        special  = word ? ext_w(spec_raw, 1'b1) : spec_raw;
    end

    // One iteration of the active algorithm plus the signed result it would finish with.
    always_comb begin
        div_sh = {acc_q[XLEN-1:0], opb_q[XLEN-1]};
        div_df = div_sh - {1'b0, opa_q[XLEN-1:0]};
        if (op_q[2]) begin
            opa_n = opa_q;
            opb_n = {opb_q[XLEN-2:0], ~div_df[XLEN]};
            acc_n = {{XLEN{1'b0}}, div_df[XLEN] ? div_sh[XLEN-1:0] : div_df[XLEN-1:0]};
        end else begin
            opa_n = opa_q << 1;
            opb_n = opb_q >> 1;
            acc_n = opb_q[0] ? acc_q + opa_q : acc_q;
        end
        prod = neg_q ? -acc_n : acc_n;
        quo  = neg_q ? -opb_n : opb_n;
        rem  = rneg_q ? -acc_n[XLEN-1:0] : acc_n[XLEN-1:0];
        if (op_q[2])
            fin_raw = op_q[1] ? rem : quo;
        else if (word_q || op_q[1:0] == 2'd0)
            fin_raw = prod[XLEN-1:0];
        else
            fin_raw = prod[2*XLEN-1:XLEN];
        fin = word_q ? ext_w(fin_raw, 1'b1) : fin_raw;
    end

    // Next-state logic: accept, iterate, hand off; flush overrides everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        word_d  = word_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        res_d   = res_q;
        case (state_q)
            IDLE: if (in_valid) begin
                op_d   = op;
                word_d = word;
                neg_d  = a_neg ^ b_neg;
                rneg_d = a_neg;
                acc_d  = '0;
                if (div0 || ovf) begin
                    state_d = DONE;
                    res_d   = special;
                end else begin
                    state_d = CALC;
                    cnt_d   = word ? CW'(WW) : CW'(XLEN);
                    if (op[2]) begin
                        opa_d = {{XLEN{1'b0}}, mag_b};
                        // Left-align the dividend so the first step sees its MSB.
                        opb_d = word ? (mag_a << (XLEN - WW)) : mag_a;
                    end else begin
                        opa_d = {{XLEN{1'b0}}, mag_a};
                        opb_d = mag_b;
                    end
                end
            end
            CALC: begin
                opa_d = opa_n;
                opb_d = opb_n;
                acc_d = acc_n;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    res_d   = fin;
                end
            end
            DONE: if (out_ready) begin
                state_d = IDLE;
                res_d   = '0;
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            res_d   = '0;
        end
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // All state, including the registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            word_q      <= 1'b0;
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
            opa_q       <= '0;
            opb_q       <= '0;
            acc_q       <= '0;
            res_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            word_q      <= word_d;
            neg_q       <= neg_d;
            rneg_q      <= rneg_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            acc_q       <= acc_d;
            res_q       <= res_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_ysyx_220066_mdu.sv
// Bench for ysyx_220066_mdu (XLEN=64): arithmetic model + cycle-level
// handshake model checked every negedge, plus literal directed vectors.
module tb_ysyx_220066_mdu;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = '0;
    logic        word = 1'b0;
    logic [63:0] src1 = '0;
    logic [63:0] src2 = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] result;

    int checks = 0;
    int errors = 0;

    ysyx_220066_mdu #(.XLEN(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .word(word), .src1(src1), .src2(src2), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Expected result straight from the RISC-V M-extension definitions.
    function automatic logic [63:0] model(input logic [2:0] o, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        logic [31:0]  r;
        int           sa32, sb32;
        longint       sa, sb;
        if (w) begin
            sa32 = $signed(a[31:0]);
            sb32 = $signed(b[31:0]);
            if (!o[2]) r = a[31:0] * b[31:0];
            else if (b[31:0] == 32'd0) r = o[1] ? a[31:0] : 32'hFFFFFFFF;
            else if (!o[0] && a[31:0] == 32'h80000000 && b[31:0] == 32'hFFFFFFFF)
                r = o[1] ? 32'd0 : a[31:0];
            else case (o[1:0])
                2'd0: r = sa32 / sb32;
                2'd1: r = a[31:0] / b[31:0];
                2'd2: r = sa32 % sb32;
                default: r = a[31:0] % b[31:0];
            endcase
            return {{32{r[31]}}, r};
        end
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            3'd0: return a * b;
            3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
            3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b}; return p[127:64]; end
            3'd3: begin p = {64'd0, a} * {64'd0, b}; return p[127:64]; end
            default: begin
                if (b == 64'd0) return o[1] ? a : 64'hFFFFFFFFFFFFFFFF;
                if (!o[0] && a == 64'h8000000000000000 && b == 64'hFFFFFFFFFFFFFFFF)
                    return o[1] ? 64'd0 : a;
                case (o[1:0])
                    2'd0: return sa / sb;
                    2'd1: return a / b;
                    2'd2: return sa % sb;
                    default: return a % b;
                endcase
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] o, input logic w,
                                      input logic [63:0] a, input logic [63:0] b);
        if (!o[2]) return 1'b0;
        if (w) return (b[31:0] == 32'd0) ||
                      (!o[0] && a[31:0] == 32'h80000000 && b[31:0] == 32'hFFFFFFFF);
        return (b == 64'd0) ||
               (!o[0] && a == 64'h8000000000000000 && b == 64'hFFFFFFFFFFFFFFFF);
    endfunction

    // Handshake model: busy for N edges after accept, or straight to done for special cases.
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    int          m_wait = 0;
    logic [63:0] m_res = '0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_wait <= 0; m_res <= '0;
        end else if (flush) begin
            m_busy <= 1'b0; m_done <= 1'b0;
        end else if (m_done) begin
            if (out_ready) m_done <= 1'b0;
        end else if (m_busy) begin
            if (m_wait == 1) begin m_busy <= 1'b0; m_done <= 1'b1; end
            m_wait <= m_wait - 1;
        end else if (in_valid) begin
            m_res <= model(op, word, src1, src2);
            if (is_special(op, word, src1, src2)) m_done <= 1'b1;
            else begin m_busy <= 1'b1; m_wait <= word ? 32 : 64; end
        end
    end

    // Compare DUT against the model every cycle.
    always @(negedge clk) begin
        chk("in_ready", in_ready, !(m_busy || m_done));
        chk("out_valid", out_valid, m_done);
        chk("result", result, m_done ? m_res : 64'd0);
    end

    // Called at a negedge with the DUT idle; returns at a negedge, idle again.
    task automatic run_op(input string nm, input logic [2:0] o, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int lat, input bit lit);
        int n;
        op = o; word = w; src1 = a; src2 = b; in_valid = 1'b1;
        @(negedge clk);
        n = 1;
        in_valid = 1'b0;
        op = 3'($urandom); word = 1'($urandom);
        src1 = {$urandom, $urandom}; src2 = {$urandom, $urandom};
        while (!out_valid && n < 200) begin @(negedge clk); n++; end
        chk({nm, "_lat"}, 64'(n), 64'(lat));
        chk({nm, "_res"}, result, exp);
        if (lit) chk({nm, "_model"}, model(o, w, a, b), exp);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [2:0]  ro;
        logic        rw;
        logic [63:0] ra, rb;
        #1 rst = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 64'd1);
        chk("rst_out_valid", out_valid, 64'd0);
        chk("rst_result", result, 64'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        run_op("mul",     3'd0, 1'b0, 64'd7, 64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFEB, 65, 1);
        run_op("mulhu",   3'd3, 1'b0, '1, '1, 64'hFFFFFFFFFFFFFFFE, 65, 1);
        run_op("mulh",    3'd1, 1'b0, '1, '1, 64'd0, 65, 1);
        run_op("mulhsu",  3'd2, 1'b0, '1, 64'd2, 64'hFFFFFFFFFFFFFFFF, 65, 1);
        run_op("divu0",   3'd5, 1'b0, 64'd100, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1, 1);
        run_op("remu0",   3'd7, 1'b0, 64'd100, 64'd0, 64'd100, 1, 1);
        run_op("divovf",  3'd4, 1'b0, 64'h8000000000000000, '1, 64'h8000000000000000, 1, 1);
        run_op("removf",  3'd6, 1'b0, 64'h8000000000000000, '1, 64'd0, 1, 1);
        run_op("divw",    3'd4, 1'b1, 64'h00000000FFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFD, 33, 1);
        run_op("remw",    3'd6, 1'b1, 64'h00000000FFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFF, 33, 1);
        run_op("div",     3'd4, 1'b0, 64'hFFFFFFFFFFFFFF9C, 64'd7, 64'hFFFFFFFFFFFFFFF2, 65, 1);
        run_op("rem",     3'd6, 1'b0, 64'hFFFFFFFFFFFFFF9C, 64'd7, 64'hFFFFFFFFFFFFFFFE, 65, 1);
        run_op("divu",    3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65, 1);
        run_op("mulw",    3'd0, 1'b1, 64'hDEADBEEF7FFFFFFF, 64'h1234567800000002, 64'hFFFFFFFFFFFFFFFE, 33, 1);
        run_op("mulhw",   3'd1, 1'b1, 64'hDEADBEEF7FFFFFFF, 64'h1234567800000002, 64'hFFFFFFFFFFFFFFFE, 33, 1);
        run_op("remuw0",  3'd7, 1'b1, 64'h0000000180000000, 64'hFFFFFFFF00000000, 64'hFFFFFFFF80000000, 1, 1);
        run_op("divwovf", 3'd4, 1'b1, 64'h0000000080000000, 64'h00000000FFFFFFFF, 64'hFFFFFFFF80000000, 1, 1);

        for (int i = 0; i < 12; i++) begin
            ro = 3'($urandom);
            rw = 1'($urandom);
            ra = (i % 3 == 0) ? 64'($urandom_range(0, 50)) : {$urandom, $urandom};
            rb = (i % 4 == 0) ? 64'($urandom_range(1, 9)) : {$urandom, $urandom};
            run_op("rand", ro, rw, ra, rb, model(ro, rw, ra, rb),
                   is_special(ro, rw, ra, rb) ? 1 : (rw ? 33 : 65), 0);
        end

        // Hold the result for 10 cycles, then release with a new request already waiting.
        op = 3'd0; word = 1'b0; src1 = 64'd5; src2 = 64'd6; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 200) begin @(negedge clk); n++; end
        chk("hold_lat", 64'(n), 64'd65);
        for (int i = 0; i < 10; i++) begin
            chk("hold_res", result, 64'd30);
            chk("hold_in_ready", in_ready, 64'd0);
            @(negedge clk);
        end
        op = 3'd5; src1 = 64'd100; src2 = 64'd0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_in_ready", in_ready, 64'd1);
        chk("release_out_valid", out_valid, 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_out_valid", out_valid, 64'd1);
        chk("b2b_res", result, 64'hFFFFFFFFFFFFFFFF);
        // Flush in DONE discards the pending result.
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_done_valid", out_valid, 64'd0);
        chk("flush_done_res", result, 64'd0);

        // Flush at CALC cycle 20, with a request held alongside it.
        op = 3'd4; word = 1'b0; src1 = 64'd1000; src2 = 64'd3; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (19) @(negedge clk);
        flush = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", in_ready, 64'd1);
        chk("flush_out_valid", out_valid, 64'd0);
        @(negedge clk);
        chk("flush_beats_accept", in_ready, 64'd1);
        flush = 1'b0; in_valid = 1'b0;
        n = 0;
        repeat (80) begin @(negedge clk); if (out_valid) n++; end
        chk("flush_quiet", 64'(n), 64'd0);

        // Reset at CALC cycle 30; outputs return to reset values without waiting for an edge.
        op = 3'd0; src1 = 64'd3; src2 = 64'd4; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (29) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready, 64'd1);
        chk("midrst_out_valid", out_valid, 64'd0);
        chk("midrst_result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("post_rst", 3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65, 1);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ysyx_220066_mdu.md
YSYX_220066_MDU -- requirements
Module: ysyx_220066_mdu

Interface
REQ-001 Parameter XLEN, default 64, operand/result width; SHALL be even and >= 8.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 word  input  1  32-bit (W) variant.
REQ-008 src1  input  XLEN  rs1 operand / dividend.
REQ-009 src2  input  XLEN  rs2 operand / divisor.
REQ-010 flush  input  1  abort the in-flight operation.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 result  output  XLEN  operation result.

Function
REQ-014 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE.
REQ-016 Accept SHALL be in_valid & in_ready at an edge; op, word and operands SHALL be latched then, and later changes on the inputs SHALL be ignored.
REQ-017 On accept of a normal op, IDLE -> CALC; a counter SHALL load N, where N = XLEN when word=0 and N = 32 when word=1.
REQ-018 CALC SHALL process one bit per cycle and go to DONE on the edge the counter reaches 0; out_valid SHALL rise exactly N+1 edges after the accept edge.
REQ-019 Multiply SHALL be radix-2 shift-add on operand magnitudes with sign fix-up at the end.
REQ-020 MUL SHALL return the low XLEN bits of the product.
REQ-021 MULH, MULHSU and MULHU SHALL return the high XLEN bits of the product, with operands signed x signed, signed x unsigned and unsigned x unsigned respectively.
REQ-022 Divide SHALL be restoring division on magnitudes.
REQ-023 Quotient sign SHALL be sign(src1) XOR sign(src2); remainder sign SHALL equal the dividend sign.
REQ-024 word=1: operands SHALL be the low 32 bits, sign-extended for signed ops and zero-extended for unsigned ops; result SHALL be the 32-bit result sign-extended from bit 31 to XLEN.
REQ-025 word=1 with op 1..3 SHALL behave as MUL with word=1.
REQ-026 Divide by zero (divisor operand, after word truncation, is 0) SHALL skip CALC: IDLE -> DONE with out_valid one edge after accept.
REQ-027 On divide by zero: DIV/DIVU result SHALL be all ones; REM/REMU result SHALL be the (extended) dividend.
REQ-028 Signed overflow (DIV/REM, dividend = most negative value, divisor = -1, at the active width) SHALL skip CALC like REQ-026.
REQ-029 On signed overflow: DIV result SHALL be the dividend; REM result SHALL be 0.
REQ-030 DONE: out_valid=1 and result SHALL hold stable until out_valid & out_ready at an edge; DONE -> IDLE on that edge.
REQ-031 No new accept SHALL occur on the same edge as DONE -> IDLE, giving minimum throughput of one op per N+2 cycles.
REQ-032 flush=1 at an edge SHALL force IDLE from any state with out_valid=0 next cycle; any pending result is discarded.
REQ-033 flush SHALL win over a simultaneous accept or a simultaneous out_ready.
REQ-034 result SHALL be 0 whenever out_valid=0.

Reset
REQ-035 rst=1 SHALL immediately force: state IDLE, in_ready=1, out_valid=0, result=0, counter=0, all datapath registers 0.
REQ-036 rst mid-CALC or in DONE SHALL discard the operation with no output handshake.
REQ-037 After rst deasserts, the first accept SHALL be possible at the next edge.

Verification (XLEN=64)
REQ-038 MUL src1=7, src2=0xFFFFFFFFFFFFFFFD -> result 0xFFFFFFFFFFFFFFEB, out_valid at accept+65.
REQ-039 MULHU src1=src2=0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFFFFFFFFFE; MULH with the same operands -> 0x0.
REQ-040 DIVU 100/0 -> 0xFFFFFFFFFFFFFFFF at accept+1; REMU 100/0 -> 100 at accept+1.
REQ-041 DIV 0x8000000000000000 / 0xFFFFFFFFFFFFFFFF -> 0x8000000000000000; REM with the same operands -> 0; both at accept+1.
REQ-042 DIVW src1=0x00000000FFFFFFF9, src2=2 -> 0xFFFFFFFFFFFFFFFD at accept+33; REMW -> 0xFFFFFFFFFFFFFFFF.
REQ-043 Hold out_ready=0 for 10 cycles in DONE -> result stable and in_ready=0 throughout; assert flush at CALC cycle 20 -> out_valid never rises and in_ready=1 next cycle; assert rst at CALC cycle 30 -> all outputs at reset values immediately.
